morse_tx: RTL and testbench

//   Morse transmitter: accepts one ASCII character per handshake and keys it out

---
 rtl/morse_tx.sv | 200 ++++++++++++++++++++
 tb/tb_morse_tx.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/morse_tx.sv
`default_nettype none
// ============================================================================
//  Module   : morse_tx
//  Purpose  : Morse transmitter. Accepts one ASCII character per valid/ready
//             handshake and keys it out on 'key' with standard unit timing
//             (dot 1u, dash 3u, element gap 1u, char gap 3u, word gap 7u).
//  Revision : 1.0  initial release
// ============================================================================
module morse_tx #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,     // asynchronous, active-low
  input  logic [7:0] char_in,
  input  logic       valid,
  output logic       ready,
  output logic       key,
  output logic       busy,
  output logic       err
);

  localparam int CW = (4 * UNIT_CYCLES > 1) ? $clog2(4 * UNIT_CYCLES) : 1;

  localparam logic [CW-1:0] c_dot  = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] c_dash = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] c_char = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] c_word = CW'(4 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MARK     = 3'd1,
    S_GAP      = 3'd2,
    S_CHAR_GAP = 3'd3,
    S_WORD_GAP = 3'd4
  } state_t;

  state_t          r_state, w_state_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic [2:0]      r_idx, w_idx_next;
  logic [2:0]      r_len;
  logic [4:0]      r_pat;
  logic            r_key;
  logic            r_err;

  logic [7:0]      w_upper;
  logic [2:0]      w_rom_len;
  logic [4:0]      w_rom_pat;
  logic            w_accept;
  logic            w_is_space;
  logic            w_supported;
  logic            w_load;
  logic            w_bad;

  // Code lookup: {len, pattern}; pattern left-aligned, MSB first, 1 = dash.
  function automatic logic [7:0] morse_rom(input logic [7:0] c);
    case (c)
      8'h41: morse_rom = {3'd2, 5'b01000}; // A .-
      8'h42: morse_rom = {3'd4, 5'b10000}; // B -...
      8'h43: morse_rom = {3'd4, 5'b10100}; // C -.-.
      8'h44: morse_rom = {3'd3, 5'b10000}; // D -..
      8'h45: morse_rom = {3'd1, 5'b00000}; // E .
      8'h46: morse_rom = {3'd4, 5'b00100}; // F ..-.
      8'h47: morse_rom = {3'd3, 5'b11000}; // G --.
      8'h48: morse_rom = {3'd4, 5'b00000}; // H ....
      8'h49: morse_rom = {3'd2, 5'b00000}; // I ..
      8'h4A: morse_rom = {3'd4, 5'b01110}; // J .---
      8'h4B: morse_rom = {3'd3, 5'b10100}; // K -.-
      8'h4C: morse_rom = {3'd4, 5'b01000}; // L .-..
      8'h4D: morse_rom = {3'd2, 5'b11000}; // M --
      8'h4E: morse_rom = {3'd2, 5'b10000}; // N -.
      8'h4F: morse_rom = {3'd3, 5'b11100}; // O ---
      8'h50: morse_rom = {3'd4, 5'b01100}; // P .--.
      8'h51: morse_rom = {3'd4, 5'b11010}; // Q --.-
      8'h52: morse_rom = {3'd3, 5'b01000}; // R .-.
      8'h53: morse_rom = {3'd3, 5'b00000}; // S ...
      8'h54: morse_rom = {3'd1, 5'b10000}; // T -
      8'h55: morse_rom = {3'd3, 5'b00100}; // U ..-
      8'h56: morse_rom = {3'd4, 5'b00010}; // V ...-
      8'h57: morse_rom = {3'd3, 5'b01100}; // W .--
      8'h58: morse_rom = {3'd4, 5'b10010}; // X -..-
      8'h59: morse_rom = {3'd4, 5'b10110}; // Y -.--
      8'h5A: morse_rom = {3'd4, 5'b11000}; // Z --..
      8'h30: morse_rom = {3'd5, 5'b11111}; // 0 -----
      8'h31: morse_rom = {3'd5, 5'b01111}; // 1 .----
      8'h32: morse_rom = {3'd5, 5'b00111}; // 2 ..---
      8'h33: morse_rom = {3'd5, 5'b00011}; // 3 ...--
      8'h34: morse_rom = {3'd5, 5'b00001}; // 4 ....-
      8'h35: morse_rom = {3'd5, 5'b00000}; // 5 .....
      8'h36: morse_rom = {3'd5, 5'b10000}; // 6 -....
      8'h37: morse_rom = {3'd5, 5'b11000}; // 7 --...
      8'h38: morse_rom = {3'd5, 5'b11100}; // 8 ---..
      8'h39: morse_rom = {3'd5, 5'b11110}; // 9 ----.
      default: morse_rom = 8'h00;          // len 0 marks unsupported
    endcase
  endfunction

  // Fold lower case, look up the code and classify the offered character.
  always_comb begin
    w_upper = char_in;
    if (char_in >= 8'h61 && char_in <= 8'h7A) begin
      w_upper = char_in - 8'h20;
    end
    {w_rom_len, w_rom_pat} = morse_rom(w_upper);
    w_accept    = valid && (r_state == S_IDLE);
    w_is_space  = (char_in == 8'h20);
    w_supported = (w_rom_len != 3'd0);
  end

  // Next-state, counter and element-index logic.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_load       = 1'b0;
    w_bad        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_supported) begin
            w_state_next = S_MARK;
            w_idx_next   = 3'd0;
            w_cnt_next   = w_rom_pat[4] ? c_dash : c_dot;
            w_load       = 1'b1;
          end else if (w_is_space) begin
            w_state_next = S_WORD_GAP;
            w_cnt_next   = c_word;
          end else begin
            w_bad = 1'b1;
          end
        end
      end
      S_MARK: begin
        if (r_cnt == '0) begin
          if ((r_idx + 3'd1) < r_len) begin
            w_state_next = S_GAP;
            w_idx_next   = r_idx + 3'd1;
            w_cnt_next   = c_dot;
          end else begin
            w_state_next = S_CHAR_GAP;
            w_cnt_next   = c_char;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_state_next = S_MARK;
          w_cnt_next   = r_pat[3'd4 - r_idx] ? c_dash : c_dot;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_CHAR_GAP, S_WORD_GAP: begin
        if (r_cnt == '0) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_idx_next   = '0;
      end
    endcase
  end

  // State, counters and latched code; reset aborts any symbol in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_pat   <= '0;
      r_key   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      if (w_load) begin
        r_len <= w_rom_len;
        r_pat <= w_rom_pat;
      end
      // Key follows the MARK state one edge later, so it rises on the edge
      // after the accepting edge.
      r_key <= (r_state == S_MARK);
      r_err <= w_bad;
    end
  end

  assign ready = (r_state == S_IDLE);
  assign busy  = ~ready;
  assign key   = r_key;
  assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_morse_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_morse_tx
//  Purpose  : Directed self-checking bench for morse_tx at UNIT_CYCLES = 2.
//  Revision : 1.0  initial release
// ============================================================================
module tb_morse_tx;

  logic       clk;
  logic       reset;
  logic [7:0] char_in;
  logic       valid;
  logic       ready;
  logic       key;
  logic       busy;
  logic       err;

  int tests = 0;
  int fails = 0;

  morse_tx #(.UNIT_CYCLES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .char_in (char_in),
    .valid   (valid),
    .ready   (ready),
    .key     (key),
    .busy    (busy),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one character; it is accepted on the next rising edge.
  task automatic drive_accept(input logic [7:0] c, input bit hold);
    @(negedge clk);
    char_in = c;
    valid   = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) valid = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    valid   = 1'b0;
    char_in = 8'h00;
    repeat (3) @(negedge clk);
    tests++; if (key   !== 1'b0) begin fails++; $display("FAIL reset_key got=%b want=0", key); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got=%b want=1", ready); end
    tests++; if (busy  !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
    tests++; if (err   !== 1'b0) begin fails++; $display("FAIL reset_err got=%b want=0", err); end
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // 'E': key 0 in the accept cycle, high 2, then low; ready back after 8.
  task automatic test_e();
    logic [8:0] ek;
    logic [8:0] er;
    ek = {1'b0, 2'b11, 6'b000000};
    er = {8'b00000000, 1'b1};
    drive_accept(8'h45, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tests++; if (key !== ek[8-i]) begin fails++; $display("FAIL e_key cyc=%0d got=%b want=%b", i, key, ek[8-i]); end
      tests++; if (ready !== er[8-i]) begin fails++; $display("FAIL e_ready cyc=%0d got=%b want=%b", i, ready, er[8-i]); end
      tests++; if (busy !== ~er[8-i]) begin fails++; $display("FAIL e_busy cyc=%0d got=%b want=%b", i, busy, ~er[8-i]); end
    end
  endtask

  task automatic test_a();
    logic [16:0] ek;
    logic [16:0] er;
    ek = {1'b0, 2'b11, 2'b00, 6'h3f, 6'h00};
    er = {16'h0000, 1'b1};
    drive_accept(8'h41, 1'b0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      tests++; if (key !== ek[16-i]) begin fails++; $display("FAIL a_key cyc=%0d got=%b want=%b", i, key, ek[16-i]); end
      tests++; if (ready !== er[16-i]) begin fails++; $display("FAIL a_ready cyc=%0d got=%b want=%b", i, ready, er[16-i]); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL a_err cyc=%0d got=%b want=0", i, err); end
    end
  endtask

  // '0' then 'a' held valid: 'a' is taken in the first IDLE cycle.
  task automatic test_back_to_back();
    logic [61:0] ek;
    logic [61:0] er;
    ek = {1'b0, 6'h3f, 2'b00, 6'h3f, 2'b00, 6'h3f, 2'b00, 6'h3f, 2'b00, 6'h3f,
          7'h00, 2'b11, 2'b00, 6'h3f, 6'h00};
    er = {44'h0, 1'b1, 16'h0000, 1'b1};
    drive_accept(8'h30, 1'b1);
    char_in = 8'h61;
    for (int i = 0; i < 62; i++) begin
      @(negedge clk);
      tests++; if (key !== ek[61-i]) begin fails++; $display("FAIL b2b_key cyc=%0d got=%b want=%b", i, key, ek[61-i]); end
      tests++; if (ready !== er[61-i]) begin fails++; $display("FAIL b2b_ready cyc=%0d got=%b want=%b", i, ready, er[61-i]); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL b2b_err cyc=%0d got=%b want=0", i, err); end
      if (i == 45) valid = 1'b0;
    end
  endtask

  task automatic test_unsupported();
    logic [2:0] ee;
    ee = 3'b100;
    drive_accept(8'h23, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (err !== ee[2-i]) begin fails++; $display("FAIL bad_err cyc=%0d got=%b want=%b", i, err, ee[2-i]); end
      tests++; if (key !== 1'b0) begin fails++; $display("FAIL bad_key cyc=%0d got=%b want=0", i, key); end
      tests++; if (ready !== 1'b1) begin fails++; $display("FAIL bad_ready cyc=%0d got=%b want=1", i, ready); end
    end
  endtask

  task automatic test_space();
    logic [8:0] er;
    er = {8'b00000000, 1'b1};
    drive_accept(8'h20, 1'b0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      tests++; if (key !== 1'b0) begin fails++; $display("FAIL sp_key cyc=%0d got=%b want=0", i, key); end
      tests++; if (ready !== er[8-i]) begin fails++; $display("FAIL sp_ready cyc=%0d got=%b want=%b", i, ready, er[8-i]); end
      tests++; if (err !== 1'b0) begin fails++; $display("FAIL sp_err cyc=%0d got=%b want=0", i, err); end
    end
  endtask

  task automatic test_reset_mid_symbol();
    drive_accept(8'h54, 1'b0);
    @(negedge clk);
    @(negedge clk);
    tests++; if (key !== 1'b1) begin fails++; $display("FAIL mid_key_pre got=%b want=1", key); end
    #1 reset = 1'b0;
    #1;
    tests++; if (key   !== 1'b0) begin fails++; $display("FAIL mid_key got=%b want=0", key); end
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL mid_ready got=%b want=1", ready); end
    tests++; if (busy  !== 1'b0) begin fails++; $display("FAIL mid_busy got=%b want=0", busy); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++; if (ready !== 1'b1) begin fails++; $display("FAIL mid_idle got=%b want=1", ready); end
    test_e();
  endtask

  initial begin
    test_reset();
    test_e();
    test_a();
    test_back_to_back();
    test_unsupported();
    test_space();
    test_reset_mid_symbol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
